// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a serialiser that
// streams frames back-to-back on tx, with a sticky overflow flag.
//
// Ports:
//   clk_sys  system clock, all logic on posedge
//   res_n    synchronous active-low reset
//   wr, din  write strobe and byte (one byte per cycle)
//   clr_ovf  clears the ovf sticky flag
//   full     FIFO holds FIFO_DEPTH bytes (registered)
//   empty    FIFO holds no bytes (registered)
//   level    FIFO occupancy
//   busy     frame in flight or FIFO not empty (registered)
//   ovf      sticky: a write was dropped because the FIFO was full
//   tx       serial line, idle high, registered
module uart_tx_fifo #(
  parameter int CLK_HZ     = 84000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk_sys,
  input  logic                        res_n,
  input  logic                        wr,
  input  logic [7:0]                  din,
  input  logic                        clr_ovf,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        busy,
  output logic                        ovf,
  output logic                        tx
);
  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;

  localparam logic [CW-1:0] DIVM1 = CW'(DIV - 1);

  if (DIV < 2) begin : g_div_chk
    $error("uart_tx_fifo: DIV must be >= 2");
  end

  if (FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_dep_chk
    $error("uart_tx_fifo: FIFO_DEPTH must be pow2 >= 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [LW-1:0] level_n;
  logic          push;
  logic          pop;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [2:0]    idx;
  logic [2:0]    idx_n;
  logic [7:0]    sh;
  logic [7:0]    sh_n;
  logic          tx_n;
  logic          bit_end;

  // Fullness is judged on the registered flag, so a pop in the
  // same cycle does not rescue a write into a full FIFO.
  assign push    = wr & ~full;
  assign bit_end = (cnt == '0);

  always_comb begin
    level_n = level;
    if (push && !pop) begin
      level_n = level + LW'(1);
    end else if (pop && !push) begin
      level_n = level - LW'(1);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!res_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
      ovf   <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      level <= level_n;
      full  <= (level_n == LW'(FIFO_DEPTH));
      empty <= (level_n == '0);
      if (wr && full) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push) begin
      mem[wptr] <= din;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    sh_n    = sh;
    pop     = 1'b0;
    tx_n    = 1'b1;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          sh_n    = mem[rptr];
          cnt_n   = DIVM1;
          state_n = START;
        end
      end
      START: begin
        tx_n = 1'b0;
        if (bit_end) begin
          cnt_n   = DIVM1;
          idx_n   = '0;
          state_n = DATA;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      DATA: begin
        tx_n = sh[0];
        if (bit_end) begin
          cnt_n = DIVM1;
          sh_n  = {1'b0, sh[7:1]};
          if (idx == 3'd7) begin
            state_n = STOP;
          end else begin
            idx_n = idx + 3'd1;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          // Chain straight into the next start bit: no idle gap.
          if (!empty) begin
            pop     = 1'b1;
            sh_n    = mem[rptr];
            cnt_n   = DIVM1;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // tx and busy trail the state by one cycle, so busy drops
  // together with the end of the last stop bit on the line.
  always_ff @(posedge clk_sys) begin
    if (!res_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      tx    <= 1'b1;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      sh    <= sh_n;
      tx    <= tx_n;
      busy  <= (state != IDLE) | ~empty;
    end
  end

endmodule
